// File: rtl/if_id_pkg.sv
// Shared types for the IF/ID pipeline buffer: occupancy encoding, entry layout
// and the default bubble instruction.
package if_id_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  function automatic entry_t make_entry(input logic [31:0] pc, input logic [31:0] instr);
    entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/Adder.sv
// 32-bit modulo-2^32 adder used for PC increment.
module Adder (
  input  logic [31:0] add,
  input  logic [31:0] originalNumber,
  output logic [31:0] result
);

  assign result = originalNumber + add;

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID skid buffer between fetch and decode with flush support.
// Optional performance counters are built when IF_ID_PERF_COUNT_EN is defined.
module if_id_buffer
  import if_id_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] out_instr
`ifdef IF_ID_PERF_COUNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam entry_t EMPTY_ENTRY = '{pc: RESET_PC, instr: NOP_INSTR};

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   push_s, pop_s;
  entry_t in_entry_s;

  assign in_ready   = (state_q != ST_FULL);
  assign out_valid  = (state_q != ST_EMPTY);
  assign push_s     = in_valid & in_ready;
  assign pop_s      = out_valid & out_ready;
  assign in_entry_s = make_entry(in_pc, in_instr);

  // Head register is reloaded with the bubble whenever the buffer drains,
  // so the outputs read straight from flops with no empty-state mux.
  assign out_pc    = head_q.pc;
  assign out_instr = head_q.instr;

  // Next-state and entry update; flush overrides every push/pop decision.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = ST_EMPTY;
      head_d  = EMPTY_ENTRY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d = ST_ONE;
            head_d  = in_entry_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            head_d = in_entry_s;
          end else if (push_s) begin
            state_d = ST_FULL;
            tail_d  = in_entry_s;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
            head_d  = EMPTY_ENTRY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            state_d = ST_ONE;
            head_d  = tail_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          head_d  = EMPTY_ENTRY;
        end
      endcase
    end
  end

  // State and entry storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= EMPTY_ENTRY;
      tail_q  <= EMPTY_ENTRY;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  Adder u_pc_adder (
    .add           (32'd4),
    .originalNumber(out_pc),
    .result        (out_pc_plus4)
  );

`ifdef IF_ID_PERF_COUNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    if (out_valid && !out_ready) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (flush) begin
      flush_count_d = flush_count_q + 32'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Counter storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: a queue scoreboard tracks buffered
// entries; each scenario task compares DUT outputs against it after each edge.
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_pc_plus4, out_instr;
`ifdef IF_ID_PERF_COUNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  sb_entry_t sb[$];
  bit seen_40;

  if_id_buffer #(.NOP_INSTR(NOP), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_pc_plus4(out_pc_plus4),
    .out_instr   (out_instr)
`ifdef IF_ID_PERF_COUNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic exp_valid();
    return sb.size() > 0;
  endfunction
  function automatic logic exp_ready();
    return sb.size() < 2;
  endfunction
  function automatic logic [31:0] exp_pc();
    return (sb.size() > 0) ? sb[0].pc : RPC;
  endfunction
  function automatic logic [31:0] exp_instr();
    return (sb.size() > 0) ? sb[0].instr : NOP;
  endfunction

  // Drive one cycle, update the scoreboard from the bench's own view of
  // occupancy, then land 1 time unit after the rising edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl, input logic rst);
    logic push, pop;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl; reset = rst;
    push = v & exp_ready();
    pop  = exp_valid() & ordy;
    if (rst || fl) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back('{pc: pc, instr: ins});
    end
    @(posedge clk);
    #1;
    if (out_valid && out_pc == 32'h40) seen_40 = 1'b1;
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 32'h5, 32'h5, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_pc !== RPC) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", out_pc, RPC); end
    n_cmp++; if (out_instr !== NOP) begin n_err++; $display("FAIL reset_instr got=%h exp=%h", out_instr, NOP); end
    n_cmp++; if (out_pc_plus4 !== 32'h0000_1004) begin n_err++; $display("FAIL reset_pc4 got=%h exp=00001004", out_pc_plus4); end
  endtask

  task automatic test_single();
    cycle(1'b1, 32'h0, 32'h2008_0005, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL single_pc got=%h exp=00000000", out_pc); end
    n_cmp++; if (out_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL single_pc4 got=%h exp=00000004", out_pc_plus4); end
    n_cmp++; if (out_instr !== 32'h2008_0005) begin n_err++; $display("FAIL single_instr got=%h exp=20080005", out_instr); end
    idle(1'b1);
    n_cmp++; if (out_valid !== exp_valid()) begin n_err++; $display("FAIL single_drain got=%b exp=%b", out_valid, exp_valid()); end
  endtask

  task automatic test_fill_drain();
    cycle(1'b1, 32'h10, 32'hAAAA_0010, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, 32'hAAAA_0014, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    n_cmp++; if (out_pc !== 32'h10) begin n_err++; $display("FAIL full_head got=%h exp=00000010", out_pc); end
    cycle(1'b1, 32'h99, 32'h99, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_pc !== exp_pc() || in_ready !== 1'b0) begin n_err++; $display("FAIL full_blocked pc=%h rdy=%b exp=%h/0", out_pc, in_ready, exp_pc()); end
    idle(1'b1);
    n_cmp++; if (out_pc !== 32'h14) begin n_err++; $display("FAIL drain1_pc got=%h exp=00000014", out_pc); end
    n_cmp++; if (out_instr !== 32'hAAAA_0014) begin n_err++; $display("FAIL drain1_instr got=%h exp=AAAA0014", out_instr); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain1_ready got=%b exp=1", in_ready); end
    idle(1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain2_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    seen_40 = 1'b0;
    cycle(1'b1, 32'h30, 32'h30, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h34, 32'h34, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 32'h40, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_instr !== NOP) begin n_err++; $display("FAIL flush_instr got=%h exp=%h", out_instr, NOP); end
    n_cmp++; if (out_pc !== RPC) begin n_err++; $display("FAIL flush_pc got=%h exp=%h", out_pc, RPC); end
    for (int i = 0; i < 3; i++) idle(1'b1);
    n_cmp++; if (seen_40 !== 1'b0) begin n_err++; $display("FAIL flush_leak got=%b exp=0", seen_40); end
    // flush from ONE while decode is also ready
    cycle(1'b1, 32'h50, 32'h50, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_one v=%b r=%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_push_pop();
    cycle(1'b1, 32'h20, 32'h20, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h24, 32'h24, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_pc !== 32'h24) begin n_err++; $display("FAIL pushpop_pc got=%h exp=00000024", out_pc); end
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL pushpop_state v=%b r=%b exp=1/1", out_valid, in_ready); end
    idle(1'b1);
  endtask

  task automatic test_hold_and_wrap();
    cycle(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got=%h exp=00000000", out_pc_plus4); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      n_cmp++; if (out_instr !== 32'h1234_5678 || out_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL hold got=%h/%h exp=FFFFFFFC/12345678", out_pc, out_instr); end
    end
    // mid-operation reset wins over flush and push
    cycle(1'b1, 32'h60, 32'h60, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h64, 32'h64, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || out_pc !== RPC) begin n_err++; $display("FAIL midreset got=%b/%h exp=0/%h", out_valid, out_pc, RPC); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'b0);
      n_cmp++;
      if (out_valid !== exp_valid() || in_ready !== exp_ready() || out_pc !== exp_pc() ||
          out_instr !== exp_instr() || out_pc_plus4 !== exp_pc() + 32'd4) begin
        n_err++;
        $display("FAIL random[%0d] got v=%b r=%b pc=%h in=%h p4=%h exp v=%b r=%b pc=%h in=%h", i,
                 out_valid, in_ready, out_pc, out_instr, out_pc_plus4,
                 exp_valid(), exp_ready(), exp_pc(), exp_instr());
      end
    end
  endtask

`ifdef IF_ID_PERF_COUNT_EN
  task automatic test_perf();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h70, 32'h70, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (stall_cycles !== 32'd5) begin n_err++; $display("FAIL perf_stall got=%0d exp=5", stall_cycles); end
    n_cmp++; if (flush_count !== 32'd2) begin n_err++; $display("FAIL perf_flush got=%0d exp=2", flush_count); end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin n_err++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_instr = 32'h0;
    seen_40 = 1'b0;
    test_reset();
    test_single();
    test_fill_drain();
    test_flush();
    test_push_pop();
    test_hold_and_wrap();
    test_random();
`ifdef IF_ID_PERF_COUNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0000, instruction word presented on out_instr when empty.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, value presented on out_pc when empty.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  fetch presents valid pc/instr this cycle.
REQ-006 in_ready  output  1  buffer accepts a word this cycle.
REQ-007 in_pc  input  32  PC of fetched word (PC register dataOut).
REQ-008 in_instr  input  32  instruction word (instruction memory data).
REQ-009 flush  input  1  discard all buffered words (branch/jump redirect).
REQ-010 out_valid  output  1  head entry valid for decode.
REQ-011 out_ready  input  1  decode consumes head this cycle.
REQ-012 out_pc  output  32  PC of head entry.
REQ-013 out_pc_plus4  output  32  out_pc + 4.
REQ-014 out_instr  output  32  instruction of head entry.

Function
REQ-015 Storage is 2 entries {pc, instr}, FIFO order; states EMPTY, ONE, FULL.
REQ-016 Push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-017 in_ready = 1 in EMPTY and ONE, 0 in FULL; driven from state only, no combinational path from out_ready.
REQ-018 out_valid = 1 in ONE and FULL; out_pc/out_instr show oldest entry.
REQ-019 Latency: word pushed in cycle N is visible on outputs in cycle N+1 at earliest.
REQ-020 EMPTY: push -> ONE; else stay.
REQ-021 ONE: push & !pop -> FULL; pop & !push -> EMPTY; push & pop -> ONE with new word as head.
REQ-022 FULL: pop -> ONE (second entry becomes head); no push possible.
REQ-023 flush has priority over push and pop: next state EMPTY, word presented in flush cycle discarded, out_valid = 0 next cycle.
REQ-024 When out_valid = 0, out_pc = RESET_PC, out_instr = NOP_INSTR, out_pc_plus4 = RESET_PC + 4.
REQ-025 out_pc_plus4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-026 Entry contents hold stable while out_valid = 1 and out_ready = 0.

Reset
REQ-027 reset = 1 at rising edge -> state EMPTY, in_ready = 1, out_valid = 0, out_pc = RESET_PC, out_instr = NOP_INSTR next cycle.
REQ-028 reset has priority over flush, push and pop; mid-operation reset discards all entries.

Configuration
REQ-029 Macro IF_ID_PERF_COUNT_EN defined: adds outputs stall_cycles[31:0] (counts cycles with out_valid & !out_ready) and flush_count[31:0] (counts cycles with flush = 1), both wrap at 2^32, cleared by reset.
REQ-030 Macro undefined: these ports and counters do not exist; all other behaviour identical.

Structure
REQ-031 Shared package if_id_pkg holds state encoding (EMPTY/ONE/FULL), entry typedef {pc[31:0], instr[31:0]}, and default NOP_INSTR constant.
REQ-032 out_pc_plus4 computed by one instance of the existing Adder sub-module (add = 4, originalNumber = out_pc); no other sub-modules.

Verification
REQ-033 Reset then in_valid=1, in_pc=0x0, in_instr=0x2008_0005, out_ready=1 -> next cycle out_valid=1, out_pc=0x0, out_pc_plus4=0x4, out_instr=0x2008_0005.
REQ-034 out_ready=0, push pc 0x10 then 0x14 -> in_ready=0 after second push; out_ready=1 -> out_pc 0x10 then 0x14, in_ready=1 after first pop.
REQ-035 FULL, flush=1 with in_valid=1 pc 0x40 -> next cycle out_valid=0, out_instr=NOP_INSTR, out_pc=RESET_PC, pc 0x40 never emitted.
REQ-036 ONE with pc 0x20, push pc 0x24 & pop same cycle -> next cycle ONE, out_pc=0x24.
REQ-037 Push in_pc=0xFFFF_FFFC -> out_pc_plus4=0x0000_0000.
REQ-038 With IF_ID_PERF_COUNT_EN: hold out_valid=1, out_ready=0 for 5 cycles, pulse flush twice -> stall_cycles=5, flush_count=2; reset -> both 0.
